// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress control FSM.
package router_pkg;

    localparam int ROUTER_ADDR_W = 2;
    localparam int ROUTER_N_DEST = 3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_fsm_if.sv
// Bundle of source/datapath signals seen by the router control FSM.
interface router_fsm_if
    import router_pkg::*;
#(
    parameter int N_DEST = ROUTER_N_DEST
);

    // Source handshake: a byte is taken on every rising edge where pkt_valid=1
    // and busy=0; while busy=1 the source holds its current byte and pkt_valid.
    logic                     pkt_valid;
    logic [ROUTER_ADDR_W-1:0] data_in;
    logic                     fifo_full;
    logic [N_DEST-1:0]        fifo_empty;
    logic [N_DEST-1:0]        soft_reset;
    logic                     parity_done;
    logic                     low_pkt_valid;

    logic                     detect_add;
    logic                     lfd_state;
    logic                     ld_state;
    logic                     full_state;
    logic                     laf_state;
    logic                     write_enb_reg;
    logic                     rst_int_reg;
    logic                     busy;
    logic [ROUTER_ADDR_W-1:0] addr_q;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, full_state, laf_state,
               write_enb_reg, rst_int_reg, busy, addr_q
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, full_state, laf_state,
               write_enb_reg, rst_int_reg, busy, addr_q
    );

endinterface

// File: rtl/router_fsm.sv
// Ingress control FSM: sequences header, payload and parity into the selected
// destination FIFO and drives source back-pressure; outputs are a Moore decode.
module router_fsm
    import router_pkg::*;
#(
    parameter int N_DEST = ROUTER_N_DEST
) (
    input  logic       clock,
    input  logic       resetn,
    router_fsm_if.slave bus,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_DA  = DECODE_ADDRESS;
    localparam logic [2:0] S_LFD = LOAD_FIRST_DATA;
    localparam logic [2:0] S_LD  = LOAD_DATA;
    localparam logic [2:0] S_FFS = FIFO_FULL_STATE;
    localparam logic [2:0] S_LAF = LOAD_AFTER_FULL;
    localparam logic [2:0] S_LP  = LOAD_PARITY;
    localparam logic [2:0] S_CPE = CHECK_PARITY_ERROR;
    localparam logic [2:0] S_WTE = WAIT_TILL_EMPTY;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       addr_ok;
    logic [3:0] empty_ext;
    logic [3:0] sreset_ext;

    assign addr_ok   = ({30'd0, bus.data_in} < 32'(N_DEST));
    assign state_dbg = state;

    // Widen the per-FIFO flags so a 2-bit address can index them for any N_DEST.
    always_comb begin
        empty_ext               = '0;
        sreset_ext              = '0;
        empty_ext[N_DEST-1:0]   = bus.fifo_empty;
        sreset_ext[N_DEST-1:0]  = bus.soft_reset;
    end

    always_comb begin
        next_state = state;
        if (state != S_DA && sreset_ext[bus.addr_q]) begin
            next_state = S_DA;
        end else begin
            case (state)
                S_DA: begin
                    if (bus.pkt_valid && addr_ok)
                        next_state = empty_ext[bus.data_in] ? S_LFD : S_WTE;
                end
                S_WTE:   if (empty_ext[bus.addr_q]) next_state = S_LFD;
                S_LFD:   next_state = S_LD;
                S_LD: begin
                    if (bus.fifo_full)       next_state = S_FFS;
                    else if (!bus.pkt_valid) next_state = S_LP;
                end
                S_FFS:   if (!bus.fifo_full) next_state = S_LAF;
                S_LAF: begin
                    if (bus.parity_done)        next_state = S_DA;
                    else if (bus.low_pkt_valid) next_state = S_LP;
                    else                        next_state = S_LD;
                end
                S_LP:    next_state = S_CPE;
                S_CPE:   next_state = bus.fifo_full ? S_FFS : S_DA;
                default: next_state = S_DA;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_DA;
            bus.addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_DA && bus.pkt_valid && addr_ok)
                bus.addr_q <= bus.data_in;
        end
    end

    always_comb begin
        bus.detect_add    = (state == S_DA);
        bus.lfd_state     = (state == S_LFD);
        bus.ld_state      = (state == S_LD);
        bus.full_state    = (state == S_FFS);
        bus.laf_state     = (state == S_LAF);
        bus.rst_int_reg   = (state == S_CPE);
        bus.write_enb_reg = (state == S_LD) || (state == S_LAF) || (state == S_LP);
        bus.busy          = (state != S_DA) && (state != S_LD);
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each packet scenario cycle by cycle.
module tb_router_fsm;
    import router_pkg::*;

    // {state, detect_add, lfd, ld, full, laf, write_enb, rst_int, busy}
    localparam logic [10:0] E_DA  = {3'd0, 8'b1000_0000};
    localparam logic [10:0] E_LFD = {3'd1, 8'b0100_0001};
    localparam logic [10:0] E_LD  = {3'd2, 8'b0010_0100};
    localparam logic [10:0] E_FFS = {3'd3, 8'b0001_0001};
    localparam logic [10:0] E_LAF = {3'd4, 8'b0000_1101};
    localparam logic [10:0] E_LP  = {3'd5, 8'b0000_0101};
    localparam logic [10:0] E_CPE = {3'd6, 8'b0000_0011};
    localparam logic [10:0] E_WTE = {3'd7, 8'b0000_0001};

    logic       clock;
    logic       resetn;
    logic [2:0] state_dbg;
    int         checks;
    int         errors;

    router_fsm_if #(.N_DEST(3)) bus ();

    router_fsm #(.N_DEST(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    wire [10:0] obs = {state_dbg, bus.detect_add, bus.lfd_state, bus.ld_state,
                       bus.full_state, bus.laf_state, bus.write_enb_reg,
                       bus.rst_int_reg, bus.busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [10:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, obs, exp);
        end
    endtask

    task automatic test_reset();
        resetn            = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 3'b111;
        bus.soft_reset    = 3'b000;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        #1;
        chk("reset_state", E_DA);
        checks++;
        if (bus.addr_q !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d want 0", bus.addr_q);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("reset_release", E_DA);
    endtask

    task automatic test_basic_packet();
        int wen_cnt;
        wen_cnt        = 0;
        bus.data_in    = 2'd0;
        bus.fifo_empty = 3'b111;
        bus.pkt_valid  = 1'b1;
        tick();
        chk("basic_lfd", E_LFD);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("basic_ld%0d", i), E_LD);
            if (bus.write_enb_reg) wen_cnt++;
        end
        bus.pkt_valid = 1'b0;
        tick();
        chk("basic_lp", E_LP);
        if (bus.write_enb_reg) wen_cnt++;
        tick();
        chk("basic_cpe", E_CPE);
        tick();
        chk("basic_da", E_DA);
        checks++;
        if (wen_cnt !== 6) begin
            errors++;
            $display("FAIL basic_wen_cycles: got %0d want 6", wen_cnt);
        end
        checks++;
        if (bus.addr_q !== 2'd0) begin
            errors++;
            $display("FAIL basic_addr: got %0d want 0", bus.addr_q);
        end
    endtask

    task automatic test_wait_till_empty();
        bus.data_in    = 2'd1;
        bus.fifo_empty = 3'b101;
        bus.pkt_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wait_wte%0d", i), E_WTE);
        end
        bus.fifo_empty = 3'b111;
        tick();
        chk("wait_lfd", E_LFD);
        checks++;
        if (bus.addr_q !== 2'd1) begin
            errors++;
            $display("FAIL wait_addr: got %0d want 1", bus.addr_q);
        end
        bus.pkt_valid = 1'b0;
        tick();
        chk("wait_ld", E_LD);
        tick();
        chk("wait_lp", E_LP);
        tick();
        chk("wait_cpe", E_CPE);
        tick();
        chk("wait_da", E_DA);
    endtask

    task automatic test_invalid_addr();
        bus.data_in   = 2'd3;
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("inval_da%0d", i), E_DA);
            checks++;
            if (bus.addr_q !== 2'd1) begin
                errors++;
                $display("FAIL inval_addr%0d: got %0d want 1", i, bus.addr_q);
            end
        end
        bus.pkt_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        bus.data_in    = 2'd2;
        bus.fifo_empty = 3'b111;
        bus.pkt_valid  = 1'b1;
        tick();
        chk("full_lfd", E_LFD);
        tick();
        chk("full_ld", E_LD);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("full_ffs%0d", i), E_FFS);
        end
        bus.fifo_full = 1'b0;
        tick();
        chk("full_laf", E_LAF);
        bus.low_pkt_valid = 1'b1;
        bus.pkt_valid     = 1'b0;
        tick();
        chk("full_laf_to_lp", E_LP);
        checks++;
        if (bus.addr_q !== 2'd2) begin
            errors++;
            $display("FAIL full_addr: got %0d want 2", bus.addr_q);
        end
        bus.low_pkt_valid = 1'b0;
        tick();
        chk("full_cpe", E_CPE);
        bus.fifo_full = 1'b1;
        tick();
        chk("full_cpe_to_ffs", E_FFS);
        bus.fifo_full = 1'b0;
        tick();
        chk("full_laf2", E_LAF);
        bus.parity_done = 1'b1;
        tick();
        chk("full_laf_to_da", E_DA);
        bus.parity_done = 1'b0;
        // Second packet: LOAD_AFTER_FULL with neither flag returns to LOAD_DATA.
        bus.data_in   = 2'd0;
        bus.pkt_valid = 1'b1;
        tick();
        chk("full2_lfd", E_LFD);
        tick();
        chk("full2_ld", E_LD);
        bus.fifo_full = 1'b1;
        tick();
        chk("full2_ffs", E_FFS);
        bus.fifo_full = 1'b0;
        tick();
        chk("full2_laf", E_LAF);
        tick();
        chk("full2_laf_to_ld", E_LD);
        bus.pkt_valid = 1'b0;
        tick();
        chk("full2_lp", E_LP);
        tick();
        chk("full2_cpe", E_CPE);
        tick();
        chk("full2_da", E_DA);
    endtask

    task automatic test_soft_reset();
        bus.data_in   = 2'd2;
        bus.pkt_valid = 1'b1;
        tick();
        chk("srst_lfd", E_LFD);
        tick();
        chk("srst_ld", E_LD);
        bus.soft_reset = 3'b001;
        tick();
        chk("srst_other_ld0", E_LD);
        tick();
        chk("srst_other_ld1", E_LD);
        bus.soft_reset = 3'b100;
        bus.fifo_full  = 1'b1;
        tick();
        chk("srst_sel_da", E_DA);
        bus.fifo_full = 1'b0;
        tick();
        chk("srst_da_ignored", E_LFD);
        tick();
        chk("srst_lfd_to_da", E_DA);
        bus.soft_reset = 3'b000;
        bus.pkt_valid  = 1'b0;
        tick();
        chk("srst_idle", E_DA);
    endtask

    task automatic test_async_reset();
        bus.data_in   = 2'd1;
        bus.pkt_valid = 1'b1;
        tick();
        chk("areset_lfd", E_LFD);
        tick();
        chk("areset_ld", E_LD);
        bus.fifo_full = 1'b1;
        tick();
        chk("areset_ffs", E_FFS);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_async", E_DA);
        checks++;
        if (bus.addr_q !== 2'd0) begin
            errors++;
            $display("FAIL areset_addr: got %0d want 0", bus.addr_q);
        end
        bus.fifo_full = 1'b0;
        bus.pkt_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("areset_after", E_DA);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_packet();
        test_wait_till_empty();
        test_invalid_addr();
        test_fifo_full();
        test_soft_reset();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
